// File: rtl/riscv_dcache_pkg.sv
// Shared types for the dcache stand-in: op codes, FSM states, request bundle and geometry helpers.
// Widths only; no logic.
package riscv_dcache_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam int         TAG_W    = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_RESPOND
  } state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      addr;
    logic [63:0]      data;
    logic [7:0]       wmask;
    logic [TAG_W-1:0] tag;
  } req_t;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/riscv_dcache_if.sv
// Dcache request/response port: valid/ready request side, response side has no backpressure.
// The requester drives the master modport, the cache model sits on the slave modport.
interface riscv_dcache_if;

  logic                            req_val;
  logic                            req_rdy;
  logic [3:0]                      req_op;
  logic [31:0]                     req_addr;
  logic [63:0]                     req_data;
  logic [7:0]                      req_wmask;
  logic [riscv_dcache_pkg::TAG_W-1:0] req_tag;
  logic                            resp_val;
  logic [63:0]                     resp_data;
  logic [riscv_dcache_pkg::TAG_W-1:0] resp_tag;

  modport master (
    output req_val, req_op, req_addr, req_data, req_wmask, req_tag,
    input  req_rdy, resp_val, resp_data, resp_tag
  );

  modport slave (
    input  req_val, req_op, req_addr, req_data, req_wmask, req_tag,
    output req_rdy, resp_val, resp_data, resp_tag
  );

endinterface

// File: rtl/riscv_dcache_tag_array.sv
// Direct-mapped valid/tag array: combinational hit lookup, single install port,
// valid bits cleared together on reset (tag contents are left as-is).
module riscv_dcache_tag_array
  import riscv_dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lk_addr,
  output logic        lk_hit,
  input  logic        inst_vld,
  input  logic [31:0] inst_addr
);

  localparam int OFF  = off_w(LINE_BYTES);
  localparam int IDX  = idx_w(LINES);
  localparam int LT_W = 32 - OFF - IDX;

  logic [LINES-1:0] valid_q, valid_d;
  logic [LT_W-1:0]  tags_q [LINES];
  logic [LT_W-1:0]  tags_d [LINES];

  logic [IDX-1:0]   lk_idx, inst_idx;
  logic [LT_W-1:0]  lk_tag, inst_tag;
  logic             unused_off;

  assign lk_idx     = lk_addr[OFF+IDX-1:OFF];
  assign lk_tag     = lk_addr[31:OFF+IDX];
  assign inst_idx   = inst_addr[OFF+IDX-1:OFF];
  assign inst_tag   = inst_addr[31:OFF+IDX];
  assign unused_off = ^{lk_addr[OFF-1:0], inst_addr[OFF-1:0]};

  assign lk_hit = valid_q[lk_idx] && (tags_q[lk_idx] == lk_tag);

  always_comb begin
    valid_d = valid_q;
    tags_d  = tags_q;
    if (inst_vld) begin
      valid_d[inst_idx] = 1'b1;
      tags_d[inst_idx]  = inst_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      tags_q  <= tags_d;
    end
  end

endmodule

// File: rtl/riscv_dcache_model.sv
// Dcache responder model: hits answer one cycle after accept, misses hold req_rdy low
// for MISS_PENALTY+1 cycles then answer; responses in order, never backpressured.
module riscv_dcache_model
  import riscv_dcache_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int LINES        = 64,
  parameter int LINE_BYTES   = 32,
  parameter int MISS_PENALTY = 8
) (
  input  logic            clk,
  input  logic            reset,
  riscv_dcache_if.slave   bus
);

  localparam int WIDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W  = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;

  state_t           state_q, state_d;
  logic             req_rdy_q, req_rdy_d;
  logic             resp_val_q, resp_val_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             cap_q, cap_d;

  req_t              in_req, acc_req;
  logic              fire, lk_hit, hit, install, acc_do, mem_we;
  logic [WIDX_W-1:0] acc_widx;
  logic [63:0]       mem [MEM_WORDS];
  logic              unused_addr;

  assign in_req = '{op:    bus.req_op,
                    addr:  bus.req_addr,
                    data:  bus.req_data,
                    wmask: bus.req_wmask,
                    tag:   bus.req_tag};

  assign fire = bus.req_val & req_rdy_q;
  // No-ops never consult or modify the tag array.
  assign hit  = ((in_req.op != OP_LOAD) && (in_req.op != OP_STORE)) || lk_hit;

  riscv_dcache_tag_array #(
    .LINES      (LINES),
    .LINE_BYTES (LINE_BYTES)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .lk_addr   (bus.req_addr),
    .lk_hit    (lk_hit),
    .inst_vld  (install),
    .inst_addr (cap_q.addr)
  );

  always_comb begin
    state_d     = state_q;
    req_rdy_d   = req_rdy_q;
    resp_val_d  = 1'b0;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    install     = 1'b0;
    acc_do      = 1'b0;
    acc_req     = in_req;

    unique case (state_q)
      ST_IDLE: begin
        req_rdy_d = 1'b1;
        if (fire) begin
          if (hit) begin
            acc_do = 1'b1;
          end else begin
            cap_d     = in_req;
            req_rdy_d = 1'b0;
            cnt_d     = CNT_W'(MISS_PENALTY - 1);
            state_d   = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        if (cnt_q == '0) begin
          install = ~reset;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESPOND: begin
        acc_do    = 1'b1;
        acc_req   = cap_q;
        req_rdy_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (acc_do) begin
      resp_val_d  = 1'b1;
      resp_tag_d  = acc_req.tag;
      resp_data_d = (acc_req.op == OP_LOAD) ? mem[acc_widx] : 64'h0;
    end
  end

  // Upper address bits alias onto the backing store.
  assign acc_widx    = acc_req.addr[WIDX_W+2:3];
  assign mem_we      = acc_do && (acc_req.op == OP_STORE) && !reset;
  assign unused_addr = ^{acc_req.addr[2:0], acc_req.addr[31:WIDX_W+3]};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (acc_req.wmask[b]) mem[acc_widx][8*b +: 8] <= acc_req.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_rdy_q   <= 1'b0;
      resp_val_q  <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_rdy_q   <= req_rdy_d;
      resp_val_q  <= resp_val_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
    end
  end

  assign bus.req_rdy   = req_rdy_q;
  assign bus.resp_val  = resp_val_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_tag  = resp_tag_q;

endmodule

// File: tb/tb_riscv_dcache_model.sv
// Directed bench for riscv_dcache_model with default geometry (64 lines x 32 B, penalty 8).
module tb_riscv_dcache_model;

  localparam int MP = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  riscv_dcache_if dif ();

  riscv_dcache_model #(
    .MEM_WORDS    (4096),
    .LINES        (64),
    .LINE_BYTES   (32),
    .MISS_PENALTY (MP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] m, input logic [12:0] t);
    dif.req_val   = 1'b1;
    dif.req_op    = op;
    dif.req_addr  = a;
    dif.req_data  = d;
    dif.req_wmask = m;
    dif.req_tag   = t;
  endtask

  task automatic idle_in();
    dif.req_val = 1'b0;
  endtask

  // Single hit: response visible right after the accept edge, gone one edge later.
  task automatic hit_req(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] m, input logic [12:0] t,
                         input logic [63:0] exp_data);
    drive(op, a, d, m, t);
    tick();
    idle_in();
    chk({nm, "_val"}, 64'(dif.resp_val), 64'd1);
    chk({nm, "_tag"}, 64'(dif.resp_tag), 64'(t));
    chk({nm, "_data"}, dif.resp_data, exp_data);
    chk({nm, "_rdy"}, 64'(dif.req_rdy), 64'd1);
    tick();
    chk({nm, "_drop"}, 64'(dif.resp_val), 64'd0);
  endtask

  // Miss: req_rdy low MP+1 cycles, single response when it rises again.
  task automatic miss_req(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [63:0] d, input logic [7:0] m, input logic [12:0] t,
                          input bit chk_data, input logic [63:0] exp_data);
    int n;
    bit early;
    drive(op, a, d, m, t);
    tick();
    idle_in();
    n = 0;
    early = 1'b0;
    while (dif.req_rdy !== 1'b1 && n < 40) begin
      if (dif.resp_val === 1'b1) early = 1'b1;
      n++;
      tick();
    end
    chk({nm, "_stall"}, 64'(n), 64'(MP + 1));
    chk({nm, "_early"}, 64'(early), 64'd0);
    chk({nm, "_val"}, 64'(dif.resp_val), 64'd1);
    chk({nm, "_tag"}, 64'(dif.resp_tag), 64'(t));
    if (chk_data) chk({nm, "_data"}, dif.resp_data, exp_data);
    tick();
    chk({nm, "_drop"}, 64'(dif.resp_val), 64'd0);
  endtask

  initial begin
    int  n;
    bit  saw;

    reset = 1'b1;
    dif.req_val = 1'b0;
    dif.req_op = 4'h0;
    dif.req_addr = '0;
    dif.req_data = '0;
    dif.req_wmask = '0;
    dif.req_tag = '0;
    repeat (3) tick();
    chk("rst_rdy", 64'(dif.req_rdy), 64'd0);
    chk("rst_val", 64'(dif.resp_val), 64'd0);
    chk("rst_data", dif.resp_data, 64'd0);
    chk("rst_tag", 64'(dif.resp_tag), 64'd0);
    reset = 1'b0;
    tick();
    chk("rel_rdy", 64'(dif.req_rdy), 64'd1);

    // Cold miss on line 8.
    miss_req("cold", 4'h0, 32'h100, 64'h0, 8'h00, 13'h1005, 1'b0, 64'h0);

    // Back-to-back store/load hits on the now-resident line.
    drive(4'h1, 32'h100, 64'h1122334455667788, 8'hFF, 13'h0011);
    tick();
    chk("b2b_st_val", 64'(dif.resp_val), 64'd1);
    chk("b2b_st_tag", 64'(dif.resp_tag), 64'h11);
    chk("b2b_st_data", dif.resp_data, 64'h0);
    drive(4'h0, 32'h100, 64'h0, 8'h00, 13'h0012);
    tick();
    idle_in();
    chk("b2b_ld_val", 64'(dif.resp_val), 64'd1);
    chk("b2b_ld_tag", 64'(dif.resp_tag), 64'h12);
    chk("b2b_ld_data", dif.resp_data, 64'h1122334455667788);
    tick();
    chk("b2b_drop", 64'(dif.resp_val), 64'd0);

    // Partial byte mask on a zeroed word.
    hit_req("clr108", 4'h1, 32'h108, 64'h0, 8'hFF, 13'h0021, 64'h0);
    hit_req("pm_st", 4'h1, 32'h108, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 13'h0022, 64'h0);
    hit_req("pm_ld", 4'h0, 32'h108, 64'h0, 8'h00, 13'h0023, 64'h00000000AAAAAAAA);

    // Eviction via same index, different tag; 0x8100 also wraps onto word 0x20.
    hit_req("ev_hit", 4'h0, 32'h100, 64'h0, 8'h00, 13'h0031, 64'h1122334455667788);
    miss_req("ev_900", 4'h0, 32'h900, 64'h0, 8'h00, 13'h0032, 1'b0, 64'h0);
    miss_req("wrap", 4'h0, 32'h8100, 64'h0, 8'h00, 13'h1033, 1'b1, 64'h1122334455667788);
    miss_req("reload", 4'h0, 32'h100, 64'h0, 8'h00, 13'h0034, 1'b1, 64'h1122334455667788);

    // Empty wmask is a responding no-change store.
    hit_req("m0_st", 4'h1, 32'h100, 64'hFFFFFFFFFFFFFFFF, 8'h00, 13'h0041, 64'h0);
    hit_req("m0_ld", 4'h0, 32'h100, 64'h0, 8'h00, 13'h0042, 64'h1122334455667788);

    // Write-allocate store miss, then hit load of the written word.
    miss_req("wa_st", 4'h1, 32'h1000, 64'hDEADBEEFCAFEF00D, 8'hFF, 13'h0051, 1'b1, 64'h0);
    hit_req("wa_ld", 4'h0, 32'h1000, 64'h0, 8'h00, 13'h0052, 64'hDEADBEEFCAFEF00D);

    // No-op, then an untouched line still misses.
    hit_req("nop", 4'h7, 32'h400, 64'h5555, 8'hFF, 13'h0ABC, 64'h0);
    miss_req("post_nop", 4'h0, 32'h400, 64'h0, 8'h00, 13'h0061, 1'b0, 64'h0);

    // Reset three cycles into a refill.
    drive(4'h0, 32'h2000, 64'h0, 8'h00, 13'h0071);
    tick();
    idle_in();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mr_rdy_rst", 64'(dif.req_rdy), 64'd0);
    reset = 1'b0;
    tick();
    chk("mr_rdy_rel", 64'(dif.req_rdy), 64'd1);
    saw = 1'b0;
    n = 0;
    while (n < 12) begin
      if (dif.resp_val !== 1'b0) saw = 1'b1;
      n++;
      tick();
    end
    chk("mr_no_resp", 64'(saw), 64'd0);
    miss_req("mr_again", 4'h0, 32'h2000, 64'h0, 8'h00, 13'h0072, 1'b0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
